// File: rtl/imem_line_buffer.sv
// Single-line instruction buffer answering fetch requests; refills the line
// word by word from the backing memory port on a miss.
module imem_line_buffer #(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WORDS  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic [ADDR_WIDTH-1:0]  reqAddr,
    output logic                   rspValid,
    input  logic                   rspReady,
    output logic [WORD_LENGTH-1:0] rspInstr,
    output logic                   rspErr,
    input  logic                   flush,
    output logic                   memReq,
    output logic [ADDR_WIDTH-1:0]  memAddr,
    input  logic                   memAck,
    input  logic [WORD_LENGTH-1:0] memData,
    input  logic                   memErr
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_up;
    logic                   r_line_valid;
    logic                   r_flushed;
    logic [TAG_W-1:0]       r_tag;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       r_cnt;
    logic [WORD_LENGTH-1:0] r_line [LINE_WORDS];
    logic                   r_rsp_valid;
    logic                   r_rsp_err;
    logic [WORD_LENGTH-1:0] r_rsp_instr;

    logic [1:0]             w_offset;
    logic [IDX_W-1:0]       w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_accept;
    logic                   w_hit;
    logic                   w_last;
    logic [WORD_LENGTH-1:0] w_fill_word;

    assign w_offset = reqAddr[1:0];
    assign w_idx    = reqAddr[IDX_W+1:2];
    assign w_tag    = reqAddr[ADDR_WIDTH-1:IDX_W+2];
    assign w_accept = reqValid && reqReady;
    assign w_hit    = r_line_valid && (w_tag == r_tag) && !flush;
    assign w_last   = (r_cnt == IDX_W'(LINE_WORDS - 1));
    // The last word is still on memData when the fill completes.
    assign w_fill_word = (r_idx == r_cnt) ? memData : r_line[r_idx];

    // r_up holds reqReady low until the first edge after reset releases.
    assign reqReady = r_up && (r_state == IDLE) && (!r_rsp_valid || rspReady);
    assign rspValid = r_rsp_valid;
    assign rspInstr = r_rsp_instr;
    assign rspErr   = r_rsp_err;
    assign memReq   = (r_state == FILL);
    assign memAddr  = {r_tag, r_cnt, 2'b00};

    // Request handling, line refill and response register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_up         <= 1'b0;
            r_line_valid <= 1'b0;
            r_flushed    <= 1'b0;
            r_tag        <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_instr  <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_line[i] <= '0;
            end
        end else begin
            r_up <= 1'b1;
            if (r_rsp_valid && rspReady) begin
                r_rsp_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_line_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        if (w_offset != 2'b00) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_instr <= '0;
                        end else if (w_hit) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_instr <= r_line[w_idx];
                        end else begin
                            r_tag        <= w_tag;
                            r_idx        <= w_idx;
                            r_cnt        <= '0;
                            r_line_valid <= 1'b0;
                            r_flushed    <= 1'b0;
                            r_state      <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (memAck) begin
                        if (memErr) begin
                            r_line_valid <= 1'b0;
                            r_cnt        <= '0;
                            r_state      <= IDLE;
                            r_rsp_valid  <= 1'b1;
                            r_rsp_err    <= 1'b1;
                            r_rsp_instr  <= '0;
                        end else begin
                            r_line[r_cnt] <= memData;
                            if (w_last) begin
                                r_cnt        <= '0;
                                r_state      <= IDLE;
                                r_line_valid <= !(r_flushed || flush);
                                r_rsp_valid  <= 1'b1;
                                r_rsp_err    <= 1'b0;
                                r_rsp_instr  <= w_fill_word;
                            end else begin
                                r_cnt <= r_cnt + IDX_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_line_buffer.sv
// Scoreboard bench for imem_line_buffer with a delayed-ack backing memory model.
module tb_imem_line_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [31:0] reqAddr = 32'h0;
    logic        rspValid;
    logic        rspReady = 1'b1;
    logic [31:0] rspInstr;
    logic        rspErr;
    logic        flush = 1'b0;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck = 1'b0;
    logic [31:0] memData = 32'h0;
    logic        memErr = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_log[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          fill_cnt = 0;
    int          err_on_ack = 0;
    bit          mem_prev = 1'b0;

    imem_line_buffer #(.WORD_LENGTH(32), .ADDR_WIDTH(32), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
        .rspValid(rspValid), .rspReady(rspReady), .rspInstr(rspInstr), .rspErr(rspErr),
        .flush(flush),
        .memReq(memReq), .memAddr(memAddr), .memAck(memAck), .memData(memData), .memErr(memErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return 32'hA000_0000 + ((a - 32'h0000_1000) >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Backing memory: each word acknowledged two cycles after it is requested.
    initial begin
        int dly;
        int ack_num;
        dly = 0;
        ack_num = 0;
        forever begin
            @(negedge clk);
            memAck = 1'b0;
            memErr = 1'b0;
            if (memReq && !rst) begin
                if (dly < 1) begin
                    dly++;
                end else begin
                    dly = 0;
                    ack_num++;
                    memAck = 1'b1;
                    memData = mdata(memAddr);
                    memErr = (ack_num == err_on_ack);
                    addr_log.push_back(memAddr);
                end
            end else begin
                dly = 0;
                ack_num = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (memReq && !mem_prev) fill_cnt++;
            mem_prev = memReq;
            if (rspValid && rspReady) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_instr", rspInstr, e.instr);
                    chk("rsp_err", {31'd0, rspErr}, {31'd0, e.err});
                    if (e.lat) chk("rsp_latency", cyc - e.cyc, 32'd1);
                end
            end
        end else begin
            mem_prev = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic req(input logic [31:0] a, input logic [31:0] ei, input logic ee,
                       input bit lat, input bit push, input bit fl);
        int n;
        exp_t e;
        reqValid = 1'b1;
        reqAddr  = a;
        flush    = fl;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!reqReady && n < 200);
        if (!reqReady) chk("req_timeout", 32'd0, 32'd1);
        e.instr = ei;
        e.err   = ee;
        e.cyc   = cyc;
        e.lat   = lat;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || memReq) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int f0;
        int n;
        // Reset: everything low while rst is held.
        repeat (2) @(negedge clk);
        chk("rst_reqReady", {31'd0, reqReady}, 32'd0);
        chk("rst_rspValid", {31'd0, rspValid}, 32'd0);
        chk("rst_rspInstr", rspInstr, 32'd0);
        chk("rst_rspErr", {31'd0, rspErr}, 32'd0);
        chk("rst_memReq", {31'd0, memReq}, 32'd0);
        chk("rst_memAddr", memAddr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_before_edge", {31'd0, reqReady}, 32'd0);
        @(negedge clk);
        chk("ready_after_edge", {31'd0, reqReady}, 32'd1);
        @(posedge clk);
        #1;

        // Cold miss to word 2 of line 0x1000.
        addr_log.delete();
        req(32'h0000_1008, 32'hA000_0002, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("fill_words", addr_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size()) chk("fill_addr", addr_log[i], 32'h0000_1000 + 32'(4 * i));
        end

        // Hit streaming, one response per cycle, no memory traffic.
        f0 = fill_cnt;
        req(32'h0000_1000, 32'hA000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        req(32'h0000_1004, 32'hA000_0001, 1'b0, 1'b1, 1'b1, 1'b0);
        req(32'h0000_100C, 32'hA000_0003, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        chk("stream_no_fill", fill_cnt, f0);

        // Backpressure holds the response and blocks new requests.
        rspReady = 1'b0;
        req(32'h0000_1004, 32'hA000_0001, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, rspValid}, 32'd1);
            chk("bp_instr", rspInstr, 32'hA000_0001);
            chk("bp_ready", {31'd0, reqReady}, 32'd0);
        end
        @(posedge clk);
        #1;
        rspReady = 1'b1;
        @(negedge clk);
        chk("bp_ready_back", {31'd0, reqReady}, 32'd1);
        drain();
        chk("bp_drained", exp_q.size(), 32'd0);

        // Misaligned access errors out without touching memory.
        f0 = fill_cnt;
        req(32'h0000_1002, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        drain();
        chk("misalign_no_fill", fill_cnt, f0);
        req(32'h0000_1004, 32'hA000_0001, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();
        chk("misalign_line_kept", fill_cnt, f0);

        // Memory error on the second ack aborts; re-request refetches.
        err_on_ack = 2;
        addr_log.delete();
        req(32'h0000_2000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        chk("memerr_acks", addr_log.size(), 32'd2);
        err_on_ack = 0;
        f0 = fill_cnt;
        req(32'h0000_2000, mdata(32'h0000_2000), 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("memerr_refetch", fill_cnt, f0 + 1);

        // Flush together with a would-be hit forces a refill.
        req(32'h0000_1000, 32'hA000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        f0 = fill_cnt;
        req(32'h0000_1000, 32'hA000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        drain();
        chk("flush_refill", fill_cnt, f0 + 1);

        // Flush during a fill: response delivered, line left invalid.
        reqValid = 1'b1;
        reqAddr  = 32'h0000_2004;
        begin
            exp_t e;
            e.instr = mdata(32'h0000_2004);
            e.err = 1'b0;
            e.cyc = 0;
            e.lat = 1'b0;
            exp_q.push_back(e);
        end
        n = 0;
        while (!memReq && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        reqValid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        drain();
        f0 = fill_cnt;
        req(32'h0000_2008, mdata(32'h0000_2008), 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("flush_in_fill_miss", fill_cnt, f0 + 1);

        // Reset in the middle of a fill.
        req(32'h0000_3000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!(memReq && memAddr == 32'h0000_3008) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midfill_reached", memAddr, 32'h0000_3008);
        rst = 1'b1;
        #1;
        chk("midfill_memReq", {31'd0, memReq}, 32'd0);
        chk("midfill_rspValid", {31'd0, rspValid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        f0 = fill_cnt;
        req(32'h0000_3000, mdata(32'h0000_3000), 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("post_reset_miss", fill_cnt, f0 + 1);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_line_buffer.md
Name: imem_line_buffer

Overview:
- Responder side of the fetch-stage instruction-memory interface: serves instruction fetch requests issued by the fetch sub-stage.
- Holds one instruction line (LINE_WORDS words) in a buffer.
- On a hit, returns the word one cycle later. On a miss, refills the whole line word by word from the backing memory port, then answers.
- Sits between the fetch/decode stage and the memory subsystem.

Parameters:
- WORD_LENGTH, 32, instruction/data word width.
- ADDR_WIDTH, 32, byte address width.
- LINE_WORDS, 4, words per line; power of two, >= 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- reqValid  in  1  fetch request valid.
- reqReady  out  1  responder can accept a request this cycle.
- reqAddr  in  ADDR_WIDTH  byte address of the instruction.
- rspValid  out  1  response valid; held until consumed.
- rspReady  in  1  fetch side consumes the response.
- rspInstr  out  WORD_LENGTH  instruction word; 0 when rspErr=1.
- rspErr  out  1  misaligned address or memory error.
- flush  in  1  invalidate the buffered line.
- memReq  out  1  backing-memory word read request.
- memAddr  out  ADDR_WIDTH  word-aligned byte address being read.
- memAck  in  1  memData valid for the current memAddr.
- memData  in  WORD_LENGTH  read data.
- memErr  in  1  memory error, qualified by memAck.

Behaviour:
- Reset (async, rst=1):
  - All outputs go to 0 immediately: reqReady, rspValid, rspInstr, rspErr, memReq, memAddr.
  - state=IDLE, lineValid=0, tag=0, wordCnt=0.
  - Reset mid-FILL aborts the fill and drops memReq in the same cycle.
  - reqReady rises the first clock edge after rst deasserts.
- Address fields:
  - offset = reqAddr[1:0].
  - word index = reqAddr[log2(LINE_WORDS)+1:2].
  - tag = remaining upper bits.
- States: IDLE, FILL.
- reqReady = (state==IDLE) && (!rspValid || rspReady). A request is accepted on reqValid && reqReady.
- Response register:
  - A rspValid && rspReady handshake clears rspValid unless a new response loads in the same edge.
  - Back-to-back hits give one response per cycle.
- IDLE, request accepted:
  - offset!=0: next cycle rspValid=1, rspErr=1, rspInstr=0. No memory access; line state unchanged.
  - Hit (lineValid, tag match, no flush this cycle): next cycle rspValid=1, rspErr=0, rspInstr=line[index]. Latency 1.
  - Miss, or flush asserted in the same cycle: latch tag and index, set wordCnt=0, lineValid=0, go to FILL. Flush wins over hit.
- FILL:
  - memReq=1 and memAddr = {tag, wordCnt, 2'b00}.
  - Each memAck with memErr=0: line[wordCnt]=memData, wordCnt+1. Memory may take any number of cycles per word.
  - memAck with wordCnt==LINE_WORDS-1: lineValid=1 (unless a flush was seen during FILL), go to IDLE, memReq drops. Next cycle rspValid=1 with line[latched index]. Miss latency = sum of ack delays + 1.
  - memAck with memErr=1: abort. lineValid=0, memReq drops, go to IDLE, next cycle rspValid=1, rspErr=1, rspInstr=0.
  - flush during FILL: the fill completes and the response is delivered, but lineValid stays 0.
  - wordCnt wraps to 0 on completion.
- flush in IDLE clears lineValid at the next edge; a response already pending is unaffected.
- At most one outstanding memory request. No request is accepted during FILL.
- memAck while memReq=0 is ignored.

Test Plan:
- Reset and cold miss:
  - Stimulus: rst pulse, memory returns word i as 0xA000_0000+i with a 2-cycle ack delay; request reqAddr=0x0000_1008.
  - Required: during reset all outputs are 0. After the request, memAddr steps 0x1000, 0x1004, 0x1008, 0x100C. Then rspValid=1, rspInstr=0xA000_0002, rspErr=0.
- Hit streaming:
  - Stimulus: after the fill, reqAddr 0x1000, 0x1004, 0x100C on consecutive cycles with rspReady=1.
  - Required: responses 0xA000_0000, 0xA000_0001, 0xA000_0003 one cycle apart, memReq stays 0.
- Backpressure:
  - Stimulus: hit response with rspReady=0 for 3 cycles.
  - Required: rspValid and rspInstr stable, reqReady=0. Once rspReady=1, handshake completes and reqReady returns to 1.
- Misaligned request:
  - Stimulus: reqAddr=0x1002.
  - Required: next cycle rspErr=1, rspInstr=0, no memReq, a later hit to 0x1004 still returns 0xA000_0001.
- Memory error and flush:
  - Stimulus: miss to 0x2000 with memErr=1 on the 2nd ack.
  - Required: rspErr=1, and re-requesting 0x2000 refetches.
  - Stimulus: flush asserted together with a request to 0x1000.
  - Required: a refill occurs.
- Reset mid-fill:
  - Stimulus: rst asserted while wordCnt=2.
  - Required: memReq=0 immediately, lineValid=0, the next request misses.
